// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the alu_adder_hold ALU stage.
//   alu_op_t     : operation encoding carried on op_IN (5-7 reserved -> SUM)
//   alu_state_t  : sequencing FSM states
//   BCD_LOW_FIX  : low-nibble decimal correction
//   BCD_HIGH_FIX : high-nibble decimal correction
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_SUM = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_EOR = 3'd3,
    OP_SR  = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DADJ = 2'd2
  } alu_state_t;

  localparam logic [7:0] BCD_LOW_FIX  = 8'h06;
  localparam logic [7:0] BCD_HIGH_FIX = 8'h60;

endpackage

// File: rtl/alu_adder_hold_bcd_adjust.sv
// -----------------------------------------------------------------------------
// bcd_adjust
// Combinational decimal correction of an 8-bit binary add/subtract result.
// Ports:
//   bin_i      : binary result from the adder hold register
//   half_i     : carry out of bit 3 from the binary operation
//   carry_i    : carry out of bit 7 from the binary operation
//   subtract_i : 1 selects SBC-style correction, 0 ADC-style
//   adj_o      : BCD-corrected byte
//   carry_o    : decimal carry out
// -----------------------------------------------------------------------------
module bcd_adjust
  import alu_pkg::*;
(
  input  logic [7:0] bin_i,
  input  logic       half_i,
  input  logic       carry_i,
  input  logic       subtract_i,
  output logic [7:0] adj_o,
  output logic       carry_o
);

  logic       low_fix;
  logic       high_fix;
  logic [8:0] low_sum;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the branches leaves it unassigned (that would infer a latch).
    low_fix  = 1'b0;
    high_fix = 1'b0;
    low_sum  = {1'b0, bin_i};
    adj_o    = bin_i;
    carry_o  = carry_i;
    if (!subtract_i) begin
      low_fix  = (bin_i[3:0] > 4'd9) || half_i;
      low_sum  = {1'b0, bin_i} + (low_fix ? {1'b0, BCD_LOW_FIX} : 9'd0);
      // A carry out of the low fix also pushes the high digit past 9.
      high_fix = low_sum[8] || (low_sum[7:4] > 4'd9) || carry_i;
      adj_o    = low_sum[7:0] + (high_fix ? BCD_HIGH_FIX : 8'h00);
      carry_o  = high_fix;
    end else begin
      // Subtraction borrows show up as missing carries from the binary add.
      adj_o   = bin_i - (half_i  ? 8'h00 : BCD_LOW_FIX)
                      - (carry_i ? 8'h00 : BCD_HIGH_FIX);
      carry_o = carry_i;
    end
  end

endmodule

// File: rtl/alu_adder_hold.sv
// -----------------------------------------------------------------------------
// alu_adder_hold
// 6502-style ALU stage: latches two operands on start, computes SUM/AND/OR/
// EOR/SR into the adder hold register, and (optionally) a BCD-adjusted result
// for the accumulator. Build macro ALU_DECIMAL_MODE_EN adds the DADJ cycle and
// BCD correction; without it (2A03 style) every operation is binary and takes
// one cycle.
// Ports:
//   clk, reset_N         : clock (rising edge), async active-low reset
//   start_EN             : one-cycle request, accepted only when idle
//   op_IN                : 0=SUM 1=AND 2=OR 3=EOR 4=SR, 5-7 act as SUM
//   aOperand_IN/bOperand_IN, carry_IN, decimal_IN, subtract_IN : operation inputs
//   systemBusWrite_EN    : drive the hold register onto systemBus_OUT
//   systemBus_OUT        : hold register or high-Z
//   decAdjustAdders_OUT  : decimal-corrected (or binary) result
//   carry_OUT, overflow_OUT, negative_OUT, zero_OUT : flags
//   busy_OUT, done_OUT   : handshake
// -----------------------------------------------------------------------------
module alu_adder_hold
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  start_EN,
  input  logic [2:0]            op_IN,
  input  logic [DATA_WIDTH-1:0] aOperand_IN,
  input  logic [DATA_WIDTH-1:0] bOperand_IN,
  input  logic                  carry_IN,
  input  logic                  decimal_IN,
  input  logic                  subtract_IN,
  input  logic                  systemBusWrite_EN,
  output logic [DATA_WIDTH-1:0] systemBus_OUT,
  output logic [DATA_WIDTH-1:0] decAdjustAdders_OUT,
  output logic                  carry_OUT,
  output logic                  overflow_OUT,
  output logic                  negative_OUT,
  output logic                  zero_OUT,
  output logic                  busy_OUT,
  output logic                  done_OUT
);

  localparam int MSB = DATA_WIDTH - 1;

  alu_state_t            state_q, state_d;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  cin_q;
  logic [DATA_WIDTH-1:0] hold_q, dadj_q;
  logic                  carry_q, ovf_q, neg_q, zero_q, done_q;

  logic [DATA_WIDTH:0]   sum9;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_c, res_v;
  logic                  dec_path;
  logic                  accept;

  // A start during the done cycle is dropped: the operation is only
  // considered finished once the done pulse has been seen.
  assign accept = start_EN && !done_q;

`ifdef ALU_DECIMAL_MODE_EN
  logic       dec_q, sub_q, half_q;
  logic [7:0] adj;
  logic       adj_c;

  assign dec_path = dec_q && !(op_q inside {OP_AND, OP_OR, OP_EOR, OP_SR});

  bcd_adjust u_bcd_adjust (
    .bin_i      (hold_q),
    .half_i     (half_q),
    .carry_i    (carry_q),
    .subtract_i (sub_q),
    .adj_o      (adj),
    .carry_o    (adj_c)
  );
`else
  logic unused_inputs;
  assign unused_inputs = decimal_IN ^ subtract_IN;
  assign dec_path      = 1'b0;
`endif

  // Binary datapath, evaluated from the latched operands during ADD.
  assign sum9 = {1'b0, a_q} + {1'b0, b_q} + {{DATA_WIDTH{1'b0}}, cin_q};

  always_comb begin
    res   = sum9[MSB:0];
    res_c = sum9[DATA_WIDTH];
    res_v = (a_q[MSB] == b_q[MSB]) && (sum9[MSB] != a_q[MSB]);
    case (op_q)
      OP_AND: begin res = a_q & b_q; res_c = 1'b0; res_v = 1'b0; end
      OP_OR:  begin res = a_q | b_q; res_c = 1'b0; res_v = 1'b0; end
      OP_EOR: begin res = a_q ^ b_q; res_c = 1'b0; res_v = 1'b0; end
      OP_SR:  begin res = {cin_q, a_q[MSB:1]}; res_c = a_q[0]; res_v = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ADD;
      ST_ADD:  state_d = dec_path ? ST_DADJ : ST_IDLE;
      ST_DADJ: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every register, datapath included, is cleared by reset because the
  // hold value and flags are visible outputs that must read 0 after reset.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      hold_q  <= '0;
      dadj_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_DECIMAL_MODE_EN
      dec_q   <= 1'b0;
      sub_q   <= 1'b0;
      half_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= op_IN;
            a_q   <= aOperand_IN;
            b_q   <= bOperand_IN;
            cin_q <= carry_IN;
`ifdef ALU_DECIMAL_MODE_EN
            dec_q <= decimal_IN;
            sub_q <= subtract_IN;
`endif
          end
        end
        ST_ADD: begin
          hold_q  <= res;
          carry_q <= res_c;
          ovf_q   <= res_v;
          neg_q   <= res[MSB];
          zero_q  <= (res == '0);
`ifdef ALU_DECIMAL_MODE_EN
          // Carry into bit 4 recovered from the sum and operand bits.
          half_q  <= a_q[4] ^ b_q[4] ^ sum9[4];
`endif
          if (!dec_path) begin
            dadj_q <= res;
            done_q <= 1'b1;
          end
        end
`ifdef ALU_DECIMAL_MODE_EN
        ST_DADJ: begin
          // N, Z and V keep their binary values.
          dadj_q  <= adj;
          carry_q <= adj_c;
          done_q  <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign systemBus_OUT       = systemBusWrite_EN ? hold_q : {DATA_WIDTH{1'bz}};
  assign decAdjustAdders_OUT = dadj_q;
  assign carry_OUT           = carry_q;
  assign overflow_OUT        = ovf_q;
  assign negative_OUT        = neg_q;
  assign zero_OUT            = zero_q;
  assign busy_OUT            = (state_q == ST_ADD) || (state_q == ST_DADJ);
  assign done_OUT            = done_q;

endmodule

// File: tb/tb_alu_adder_hold.sv
// -----------------------------------------------------------------------------
// tb_alu_adder_hold
// Directed self-checking bench for alu_adder_hold. Decimal expectations follow
// ALU_DECIMAL_MODE_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_alu_adder_hold;

  logic       clk;
  logic       reset_N;
  logic       start_EN;
  logic [2:0] op_IN;
  logic [7:0] a_in, b_in;
  logic       carry_IN, decimal_IN, subtract_IN, bus_we;
  wire  [7:0] sys_bus;
  logic [7:0] dadj;
  logic       c_o, v_o, n_o, z_o, busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc, bcyc;

  alu_adder_hold #(.DATA_WIDTH(8)) dut (
    .clk                 (clk),
    .reset_N             (reset_N),
    .start_EN            (start_EN),
    .op_IN               (op_IN),
    .aOperand_IN         (a_in),
    .bOperand_IN         (b_in),
    .carry_IN            (carry_IN),
    .decimal_IN          (decimal_IN),
    .subtract_IN         (subtract_IN),
    .systemBusWrite_EN   (bus_we),
    .systemBus_OUT       (sys_bus),
    .decAdjustAdders_OUT (dadj),
    .carry_OUT           (c_o),
    .overflow_OUT        (v_o),
    .negative_OUT        (n_o),
    .zero_OUT            (z_o),
    .busy_OUT            (busy),
    .done_OUT            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic n, v, c, z);
    check({tag, ".N"}, {15'd0, n_o}, {15'd0, n});
    check({tag, ".V"}, {15'd0, v_o}, {15'd0, v});
    check({tag, ".C"}, {15'd0, c_o}, {15'd0, c});
    check({tag, ".Z"}, {15'd0, z_o}, {15'd0, z});
  endtask

  // Pulses start for one cycle, then waits (bounded) for done. Returns the
  // number of clock edges from the start edge to done and the busy cycles seen.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, b,
                        input logic c, d, s, output int cycles, output int busy_cycles);
    if (done) begin
      @(posedge clk); #1;
    end
    op_IN = op; a_in = a; b_in = b; carry_IN = c; decimal_IN = d; subtract_IN = s;
    start_EN = 1'b1;
    @(posedge clk); #1;
    start_EN = 1'b0;
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 10) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
    check("done_seen", {15'd0, done}, 16'd1);
  endtask

  initial begin
    reset_N = 1'b0; start_EN = 1'b0; op_IN = 3'd0; a_in = 8'h00; b_in = 8'h00;
    carry_IN = 1'b0; decimal_IN = 1'b0; subtract_IN = 1'b0; bus_we = 1'b1;
    #12;
    check("rst.bus",  {8'd0, sys_bus}, 16'h0000);
    check("rst.dadj", {8'd0, dadj}, 16'h0000);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.busy", {15'd0, busy}, 16'd0);
    check("rst.done", {15'd0, done}, 16'd0);
    reset_N = 1'b1;
    @(posedge clk); #1;

    // Binary add with signed overflow.
    run_op(3'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, cyc, bcyc);
    check("add.cycles", cyc[15:0], 16'd1);
    check("add.busy",   bcyc[15:0], 16'd1);
    check("add.bus",    {8'd0, sys_bus}, 16'h0080);
    check("add.dadj",   {8'd0, dadj}, 16'h0080);
    check_flags("add", 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("add.pulse",  {15'd0, done}, 16'd0);
    check("add.hold",   {8'd0, sys_bus}, 16'h0080);

    // Logic op clears C and V.
    run_op(3'd3, 8'hF0, 8'hFF, 1'b1, 1'b0, 1'b0, cyc, bcyc);
    check("eor.bus", {8'd0, sys_bus}, 16'h000F);
    check_flags("eor", 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap-around.
    run_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, cyc, bcyc);
    check("wrap.bus", {8'd0, sys_bus}, 16'h0000);
    check_flags("wrap", 1'b0, 1'b0, 1'b1, 1'b1);

    // Shift right with carry in.
    run_op(3'd4, 8'h81, 8'h55, 1'b1, 1'b0, 1'b0, cyc, bcyc);
    check("sr.bus", {8'd0, sys_bus}, 16'h00C0);
    check_flags("sr", 1'b1, 1'b0, 1'b1, 1'b0);

    run_op(3'd1, 8'hCC, 8'hAA, 1'b1, 1'b0, 1'b0, cyc, bcyc);
    check("and.bus", {8'd0, sys_bus}, 16'h0088);
    run_op(3'd2, 8'h0C, 8'h30, 1'b0, 1'b0, 1'b0, cyc, bcyc);
    check("or.bus",  {8'd0, sys_bus}, 16'h003C);
    // Reserved encoding behaves as SUM.
    run_op(3'd6, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, cyc, bcyc);
    check("rsv.bus", {8'd0, sys_bus}, 16'h0031);

    // Decimal add 58 + 46 + 1.
    run_op(3'd0, 8'h58, 8'h46, 1'b1, 1'b1, 1'b0, cyc, bcyc);
    check("dadd.bus", {8'd0, sys_bus}, 16'h009F);
`ifdef ALU_DECIMAL_MODE_EN
    check("dadd.cycles", cyc[15:0], 16'd2);
    check("dadd.busy",   bcyc[15:0], 16'd2);
    check("dadd.dadj",   {8'd0, dadj}, 16'h0005);
    check_flags("dadd", 1'b1, 1'b1, 1'b1, 1'b0);
`else
    check("dadd.cycles", cyc[15:0], 16'd1);
    check("dadd.dadj",   {8'd0, dadj}, 16'h009F);
    check_flags("dadd", 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Decimal subtract 46 - 12.
    run_op(3'd0, 8'h46, 8'hED, 1'b1, 1'b1, 1'b1, cyc, bcyc);
    check("dsub.dadj", {8'd0, dadj}, 16'h0034);
    check("dsub.C",    {15'd0, c_o}, 16'd1);
`ifdef ALU_DECIMAL_MODE_EN
    check("dsub.cycles", cyc[15:0], 16'd2);
`else
    check("dsub.cycles", cyc[15:0], 16'd1);
`endif

    // Start held high while busy and during done must not start a second op.
    @(posedge clk); #1;
    op_IN = 3'd0; a_in = 8'h01; b_in = 8'h02; carry_IN = 1'b0;
    decimal_IN = 1'b0; subtract_IN = 1'b0;
    start_EN = 1'b1;
    @(posedge clk); #1;
    check("ign.busy", {15'd0, busy}, 16'd1);
    a_in = 8'h40; b_in = 8'h40;
    @(posedge clk); #1;
    check("ign.done", {15'd0, done}, 16'd1);
    check("ign.bus",  {8'd0, sys_bus}, 16'h0003);
    @(posedge clk); #1;
    start_EN = 1'b0;
    check("ign.nobusy", {15'd0, busy}, 16'd0);
    @(posedge clk); #1;
    check("ign.hold",   {8'd0, sys_bus}, 16'h0003);
    check("ign.nodone", {15'd0, done}, 16'd0);

    // Bus released when not enabled.
    bus_we = 1'b0;
    #1;
    checks++;
    assert (sys_bus === 8'hzz)
    else begin
      failures++;
      $error("FAIL hiz observed=%h expected=zz", sys_bus);
    end
    bus_we = 1'b1;
    #1;
    check("bus.reen", {8'd0, sys_bus}, 16'h0003);
    @(posedge clk); #1;

    // Reset in the middle of an operation (DADJ when decimal is built in).
    op_IN = 3'd0; a_in = 8'h58; b_in = 8'h46; carry_IN = 1'b1; decimal_IN = 1'b1;
    start_EN = 1'b1;
    @(posedge clk); #1;
    start_EN = 1'b0;
`ifdef ALU_DECIMAL_MODE_EN
    @(posedge clk); #1;
`endif
    check("mid.busy", {15'd0, busy}, 16'd1);
    reset_N = 1'b0;
    #1;
    check("mid.bus",  {8'd0, sys_bus}, 16'h0000);
    check("mid.dadj", {8'd0, dadj}, 16'h0000);
    check_flags("mid", 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid.busy0", {15'd0, busy}, 16'd0);
    check("mid.done0", {15'd0, done}, 16'd0);
    #2;
    reset_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid.nodone", {15'd0, done}, 16'd0);
    end

    // Normal operation resumes after the abort.
    run_op(3'd0, 8'h22, 8'h11, 1'b0, 1'b0, 1'b0, cyc, bcyc);
    check("post.bus", {8'd0, sys_bus}, 16'h0033);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
